bus_trace_monitor: RTL and testbench

- Synthesizable, parametrised monitor on the core↔memory bus; the next generation of the team's simulation-only halt/MMIO watcher.
- Detects the halt address, enforces a cycle-budget timeout and captures MMIO-window accesses into a trace FIFO with a valid/ready drain port.
- Sits beside the core/memory pair in the top level and in the bench. Usable on FPGA, where the trace port feeds a UART or logic analyser.

---
 rtl/bus_trace_monitor.sv | 176 +++++++++++++++++
 tb/tb_bus_trace_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bus_trace_monitor
// Purpose  : Synthesizable watcher for the core<->memory bus. Ends a run
//            when the halt address is seen, enforces a RUN-cycle budget,
//            and logs MMIO-window accesses into a small trace FIFO that is
//            drained through a valid/ready port.
// Build    : define BUS_TRACE_READ_LOG_EN to also log MMIO reads
//            (trace_we=0, trace_data=bus_rdata). Otherwise only writes
//            are logged.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            arm                 - pulse; starts a run from IDLE/HALTED/TIMEOUT
//            bus_address/we/wdata/rdata - observed bus
//            trace_valid/ready   - FIFO head handshake
//            trace_we/addr/data  - FIFO head entry (zero when empty)
//            running/halted/timed_out - state flags
//            overflow            - sticky, a capture was dropped this run
//            cycle_count         - RUN cycles elapsed (saturating)
//            mmio_count          - captures accepted this run (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module bus_trace_monitor #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR      = 32'h0000_0FFC,
  parameter int                MMIO_BIT       = 11,
  parameter int                TIMEOUT_CYCLES = 2000,
  parameter int                FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic              bus_we,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic              trace_we,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic              running,
  output logic              halted,
  output logic              timed_out,
  output logic              overflow,
  output logic [31:0]       cycle_count,
  output logic [15:0]       mmio_count
);

  localparam int               c_AW           = $clog2(FIFO_DEPTH);
  localparam int               c_PW           = c_AW + 1;
  localparam int               c_EW           = 1 + ADDR_W + DATA_W;
  localparam logic [31:0]      c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [c_PW-1:0]  c_PTR_ONE      = c_PW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_cycle_count;
  logic [15:0]      r_mmio_count;
  logic             r_overflow;
  logic [c_EW-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;

  logic             w_dir_ok;
  logic             w_hit_halt;
  logic             w_capture;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_timeout_hit;
  logic [DATA_W-1:0] w_cap_data;
  logic [c_EW-1:0]  w_head;

`ifdef BUS_TRACE_READ_LOG_EN
  assign w_dir_ok = 1'b1;
`else
  assign w_dir_ok = bus_we;
`endif

  assign w_hit_halt    = (bus_address == HALT_ADDR);
  // The halt access itself is never logged; capture uses the state at the
  // start of the cycle, so the arming edge never captures.
  assign w_capture     = (r_state == S_RUN) && bus_address[MMIO_BIT] &&
                         !w_hit_halt && w_dir_ok;
  assign w_cap_data    = bus_we ? bus_wdata : bus_rdata;
  assign w_timeout_hit = (r_cycle_count == c_TIMEOUT_LAST);

  // Pointers carry one extra wrap bit: equal -> empty, MSB differs with
  // equal index -> full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = !w_empty && trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && w_full && !w_pop;

  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {bus_we, bus_address, w_cap_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cycle_count <= '0;
      r_mmio_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      case (r_state)
        S_RUN: begin
          if (w_push && (r_mmio_count != 16'hFFFF)) begin
            r_mmio_count <= r_mmio_count + 16'd1;
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
          // Halt has priority over the budget. The edge that ends the run
          // does not advance the count, so a timed-out run reads
          // TIMEOUT_CYCLES-1.
          if (w_hit_halt) begin
            r_state <= S_HALTED;
          end else if (w_timeout_hit) begin
            r_state <= S_TIMEOUT;
          end else if (r_cycle_count != 32'hFFFF_FFFF) begin
            r_cycle_count <= r_cycle_count + 32'd1;
          end
        end
        default: begin
          // Arming clears the run statistics but keeps queued trace
          // entries so the consumer can still drain them.
          if (arm) begin
            r_state       <= S_RUN;
            r_cycle_count <= '0;
            r_mmio_count  <= '0;
            r_overflow    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign trace_valid = !w_empty;
  assign {trace_we, trace_addr, trace_data} = w_empty ? '0 : w_head;

  assign running     = (r_state == S_RUN);
  assign halted      = (r_state == S_HALTED);
  assign timed_out   = (r_state == S_TIMEOUT);
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;
  assign mmio_count  = r_mmio_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_trace_monitor
// Purpose  : Self-checking bench for bus_trace_monitor (TIMEOUT_CYCLES=10,
//            FIFO_DEPTH=4). A queue-based reference model tracks the
//            expected outputs; directed scenarios pin literal values, then
//            randomized traffic runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_trace_monitor;

  localparam int          T_OUT = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'h0000_0FFC;
`ifdef BUS_TRACE_READ_LOG_EN
  localparam bit READLOG = 1'b1;
`else
  localparam bit READLOG = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset, arm, bus_we, trace_ready;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic        trace_valid, trace_we, running, halted, timed_out, overflow;
  logic [31:0] trace_addr, trace_data, cycle_count;
  logic [15:0] mmio_count;

  bus_trace_monitor #(
    .ADDR_W(32), .DATA_W(32), .HALT_ADDR(HALT), .MMIO_BIT(11),
    .TIMEOUT_CYCLES(T_OUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .bus_address(bus_address), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_we(trace_we), .trace_addr(trace_addr), .trace_data(trace_data),
    .running(running), .halted(halted), .timed_out(timed_out),
    .overflow(overflow), .cycle_count(cycle_count), .mmio_count(mmio_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        m_ent;
  int          m_state = M_IDLE;
  logic [31:0] m_cyc   = '0;
  logic [15:0] m_mmio  = '0;
  logic        m_ovf   = 1'b0;
  bit          m_pop, m_hit, m_cap;

  always @(posedge clk) begin
    if (reset) begin
      m_state = M_IDLE;
      q.delete();
      m_cyc  = '0;
      m_mmio = '0;
      m_ovf  = 1'b0;
    end else begin
      m_pop = (q.size() != 0) && trace_ready;
      m_hit = (bus_address == HALT);
      m_cap = (m_state == M_RUN) && bus_address[11] && !m_hit && (bus_we || READLOG);
      if (m_pop) q.delete(0);
      if (m_cap) begin
        if (q.size() < DEPTH) begin
          m_ent.we   = bus_we;
          m_ent.addr = bus_address;
          m_ent.data = bus_we ? bus_wdata : bus_rdata;
          q.push_back(m_ent);
          if (m_mmio != 16'hFFFF) m_mmio = m_mmio + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_state == M_RUN) begin
        if (m_hit) m_state = M_HALTED;
        else if (m_cyc == 32'(T_OUT - 1)) m_state = M_TIMEOUT;
        else if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
      end else if (arm) begin
        m_state = M_RUN;
        m_cyc   = '0;
        m_mmio  = '0;
        m_ovf   = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("running",     running,     m_state == M_RUN);
      check("halted",      halted,      m_state == M_HALTED);
      check("timed_out",   timed_out,   m_state == M_TIMEOUT);
      check("overflow",    overflow,    m_ovf);
      check("cycle_count", cycle_count, m_cyc);
      check("mmio_count",  mmio_count,  m_mmio);
      check("trace_valid", trace_valid, q.size() != 0);
      check("trace_we",    trace_we,    (q.size() != 0) ? q[0].we   : 1'b0);
      check("trace_addr",  trace_addr,  (q.size() != 0) ? q[0].addr : 32'd0);
      check("trace_data",  trace_data,  (q.size() != 0) ? q[0].data : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_address = 32'd0; bus_we = 1'b0; bus_wdata = 32'd0; bus_rdata = 32'd0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_address = a; bus_we = 1'b1; bus_wdata = d; tick(); idle_bus();
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trace_ready = 1'b0; idle_bus();
    tick(); tick();
    check("reset_valid", trace_valid, 1'b0);
    check("reset_cnt",   {cycle_count, mmio_count, overflow}, '0);
    check("reset_state", {running, halted, timed_out}, 3'b000);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Single MMIO write, visible one edge after the push.
    pulse_arm();
    trace_ready = 1'b1;
    wr(32'h0000_0800, 32'hDEAD_BEEF);
    check("w1_valid", trace_valid, 1'b1);
    check("w1_addr",  trace_addr,  32'h800);
    check("w1_data",  trace_data,  32'hDEAD_BEEF);
    check("w1_we",    trace_we,    1'b1);
    check("w1_mmio",  mmio_count,  16'd1);

    // Halt access: not logged, later writes ignored.
    wr(HALT, 32'h1111_1111);
    check("halt_flag",  {halted, running}, 2'b10);
    check("halt_valid", trace_valid, 1'b0);
    wr(32'h0000_0800, 32'h2222_2222);
    check("post_halt_valid", trace_valid, 1'b0);
    check("post_halt_mmio",  mmio_count,  16'd1);

    // Budget exhaustion on an idle bus.
    pulse_arm();
    repeat (T_OUT - 1) tick();
    check("to_pre_state", {running, timed_out}, 2'b10);
    check("to_pre_cnt",   cycle_count, 32'd9);
    tick();
    check("to_state", {running, timed_out}, 2'b01);
    check("to_cnt",   cycle_count, 32'd9);

    // Halt on the same edge as the budget: halt wins.
    pulse_arm();
    repeat (T_OUT - 1) tick();
    bus_address = HALT; tick(); idle_bus();
    check("tie_state", {halted, timed_out}, 2'b10);

    // Overfill a stalled FIFO, then drain in order.
    trace_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 6; i++) wr(32'h800 + 32'(4 * i), 32'hA0 + 32'(i));
    check("ovf_flag", overflow, 1'b1);
    check("ovf_mmio", mmio_count, 16'd4);
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", trace_addr, 32'h800 + 32'(4 * i));
      check("drain_data", trace_data, 32'hA0 + 32'(i));
      tick();
    end
    check("drain_empty", trace_valid, 1'b0);

    // Full FIFO accepts a push that coincides with a pop.
    trace_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 4; i++) wr(32'h800 + 32'(4 * i), 32'hB0 + 32'(i));
    trace_ready = 1'b1;
    wr(32'h0000_0900, 32'h55);
    check("fullpop_ovf",  overflow,   1'b0);
    check("fullpop_mmio", mmio_count, 16'd5);
    check("fullpop_head", trace_addr, 32'h804);
    tick();
    trace_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_valid", trace_valid, 1'b0);
    check("rst_cnt",   {cycle_count, mmio_count, overflow}, '0);
    check("rst_state", {running, halted, timed_out}, 3'b000);

    // MMIO read: logged only with the read-log build.
    pulse_arm();
    bus_address = 32'h804; bus_we = 1'b0; bus_rdata = 32'h1234; tick(); idle_bus();
    check("rd_valid", trace_valid, READLOG);
    check("rd_mmio",  mmio_count,  READLOG ? 16'd1 : 16'd0);
    check("rd_we",    trace_we,    1'b0);
    check("rd_data",  trace_data,  READLOG ? 32'h1234 : 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int sel;
      int bias;
      bias  = (c / 150) % 4;
      reset = ($urandom_range(0, 299) == 0);
      arm   = ($urandom_range(0, 7) == 0);
      sel   = $urandom_range(0, 31);
      if (sel == 0)      bus_address = HALT;
      else if (sel < 18) bus_address = 32'h800 | (32'($urandom_range(0, 511)) << 2);
      else               bus_address = $urandom;
      bus_we      = $urandom_range(0, 1) == 1;
      bus_wdata   = $urandom;
      bus_rdata   = $urandom;
      trace_ready = ($urandom_range(0, 3) < bias);
      tick();
    end
    reset = 1'b0; arm = 1'b0; idle_bus();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
